// File: rtl/tlu_pkg.sv
// tlu_pkg: shared constants and FSM encoding for the TLU receiver.
package tlu_pkg;

    localparam int TLU_ID_W     = 15;
    localparam int TLU_MIN_HALF = 2;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_WAIT_LOW = 5'b00010,
        ST_CLK_HI   = 5'b00100,
        ST_CLK_LO   = 5'b01000,
        ST_DONE     = 5'b10000
    } tlu_state_t;

    function automatic logic [7:0] half_period(input logic [7:0] div);
        return (div < 8'(TLU_MIN_HALF)) ? 8'(TLU_MIN_HALF) : div;
    endfunction

endpackage

// File: rtl/tlu_sync2.sv
// tlu_sync2: two-flop synchronizer for asynchronous TLU lines.
module tlu_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/tlu_rx.sv
// tlu_rx: DUT-side TLU handshake; catches a trigger, clocks in the
// 15-bit trigger ID and hands it to the readout with valid/ack.
module tlu_rx
    import tlu_pkg::*;
#(
    parameter bit INV_OUT = 1'b0
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        ENABLE,
    input  logic [7:0]  CONF_CLK_DIV,
    input  logic [15:0] CONF_TIME_OUT,
    input  logic        TLU_TRIGGER,
    input  logic        TLU_RESET,
    output logic        TLU_BUSY,
    output logic        TLU_CLOCK,
    output logic [14:0] TRIG_ID,
    output logic        TRIG_VALID,
    input  logic        TRIG_ACK,
    output logic [31:0] TRIG_CNT,
    output logic        TIME_OUT
);

    tlu_state_t    r_state;
    logic          r_busy;
    logic          r_clk;
    logic          r_valid;
    logic          r_time_out;
    logic          r_armed;
    logic [15:0]   r_tmo;
    logic [7:0]    r_hcnt;
    logic [3:0]    r_bit;
    logic [14:0]   r_sr;
    logic [14:0]   r_id;
    logic [31:0]   r_cnt;

    logic          w_trig_s;
    logic          w_rst_s;
    logic [7:0]    w_half;
    logic [14:0]   w_sr_next;
    logic          w_last_bit;
    logic          w_frame_end;

    tlu_sync2 u_sync_trig (
        .i_clk (SYS_CLK),
        .i_rst (SYS_RST),
        .i_d   (TLU_TRIGGER ^ INV_OUT),
        .o_q   (w_trig_s)
    );

    tlu_sync2 u_sync_rst (
        .i_clk (SYS_CLK),
        .i_rst (SYS_RST),
        .i_d   (TLU_RESET ^ INV_OUT),
        .o_q   (w_rst_s)
    );

    assign w_half      = half_period(CONF_CLK_DIV);
    assign w_sr_next   = {w_trig_s, r_sr[14:1]};
    assign w_last_bit  = (r_bit == 4'(TLU_ID_W - 1));
    assign w_frame_end = (r_state == ST_CLK_LO) && (r_hcnt == 8'd0)
                         && w_last_bit;

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_clk      <= 1'b0;
            r_valid    <= 1'b0;
            r_time_out <= 1'b0;
            r_armed    <= 1'b0;
            r_tmo      <= 16'd0;
            r_hcnt     <= 8'd0;
            r_bit      <= 4'd0;
            r_sr       <= 15'd0;
            r_id       <= 15'd0;
        end else begin
            r_time_out <= 1'b0;
            r_armed    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // armed means trig_s was low last cycle in IDLE
                    r_armed <= ~w_trig_s;
                    if (r_armed && w_trig_s && ENABLE) begin
                        r_state <= ST_WAIT_LOW;
                        r_busy  <= 1'b1;
                        r_tmo   <= CONF_TIME_OUT;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!w_trig_s) begin
                        r_state <= ST_CLK_HI;
                        r_clk   <= 1'b1;
                        r_hcnt  <= w_half - 8'd1;
                        r_bit   <= 4'd0;
                    end else if (CONF_TIME_OUT != 16'd0 && r_tmo == 16'd0) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_time_out <= 1'b1;
                    end else if (r_tmo != 16'd0) begin
                        r_tmo <= r_tmo - 16'd1;
                    end
                end
                ST_CLK_HI: begin
                    if (r_hcnt == 8'd0) begin
                        r_state <= ST_CLK_LO;
                        r_clk   <= 1'b0;
                        r_hcnt  <= w_half - 8'd1;
                    end else begin
                        r_hcnt <= r_hcnt - 8'd1;
                    end
                end
                ST_CLK_LO: begin
                    if (r_hcnt == 8'd0) begin
                        r_sr <= w_sr_next;
                        if (w_last_bit) begin
                            r_state <= ST_DONE;
                            r_id    <= w_sr_next;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_CLK_HI;
                            r_clk   <= 1'b1;
                            r_hcnt  <= w_half - 8'd1;
                            r_bit   <= r_bit + 4'd1;
                        end
                    end else begin
                        r_hcnt <= r_hcnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    if (TRIG_ACK && r_valid) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_clk   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // master reset wins over a completing frame
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_cnt <= 32'd0;
        end else if (w_rst_s) begin
            r_cnt <= 32'd0;
        end else if (w_frame_end) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign TLU_BUSY   = r_busy ^ INV_OUT;
    assign TLU_CLOCK  = r_clk ^ INV_OUT;
    assign TRIG_ID    = r_id;
    assign TRIG_VALID = r_valid;
    assign TRIG_CNT   = r_cnt;
    assign TIME_OUT   = r_time_out;

endmodule

// File: tb/tb_tlu_rx.sv
// tb_tlu_rx: directed bench for tlu_rx; instance 0 plain pins,
// instance 1 inverted pins, with a behavioural TLU master.
module tb_tlu_rx;

    logic        clk;
    logic        rst;
    logic        en    [2];
    logic [7:0]  div   [2];
    logic [15:0] tmo   [2];
    logic        trg   [2];
    logic        trst  [2];
    logic        ack   [2];
    logic        busy  [2];
    logic        tclk  [2];
    logic [14:0] id    [2];
    logic        vld   [2];
    logic [31:0] cnt   [2];
    logic        to    [2];

    int checks = 0;
    int errors = 0;

    tlu_rx #(.INV_OUT(1'b0)) dut0 (
        .SYS_CLK(clk), .SYS_RST(rst), .ENABLE(en[0]),
        .CONF_CLK_DIV(div[0]), .CONF_TIME_OUT(tmo[0]),
        .TLU_TRIGGER(trg[0]), .TLU_RESET(trst[0]),
        .TLU_BUSY(busy[0]), .TLU_CLOCK(tclk[0]),
        .TRIG_ID(id[0]), .TRIG_VALID(vld[0]), .TRIG_ACK(ack[0]),
        .TRIG_CNT(cnt[0]), .TIME_OUT(to[0])
    );

    tlu_rx #(.INV_OUT(1'b1)) dut1 (
        .SYS_CLK(clk), .SYS_RST(rst), .ENABLE(en[1]),
        .CONF_CLK_DIV(div[1]), .CONF_TIME_OUT(tmo[1]),
        .TLU_TRIGGER(trg[1]), .TLU_RESET(trst[1]),
        .TLU_BUSY(busy[1]), .TLU_CLOCK(tclk[1]),
        .TRIG_ID(id[1]), .TRIG_VALID(vld[1]), .TRIG_ACK(ack[1]),
        .TRIG_CNT(cnt[1]), .TIME_OUT(to[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pin(input int s, input logic v);
        return v ^ (s == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // master: raise trigger, drop it on busy, then put ID bit k on the
    // line at each TLU_CLOCK rise (LSB first)
    task automatic run_frame(input int s, input logic [14:0] fid,
                             input int h, input int stop_bit,
                             input int en_bit);
        int n, pulses, run, bad, busy_lo, first, len;
        logic prev, c, done;
        repeat (4) @(negedge clk);
        trg[s] = pin(s, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pin(s, busy[s]) !== 1'b1 && n < 50);
        if (stop_bit == 16) chk("busy_latency", n, 3);
        trg[s] = pin(s, 1'b0);
        pulses = 0; run = 0; bad = 0; busy_lo = 0;
        first = 0; len = 0; prev = 1'b0; done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            c = pin(s, tclk[s]);
            if (pin(s, busy[s]) !== 1'b1) busy_lo++;
            if (c && !prev) begin
                if (pulses > 0 && run != h) bad++;
                pulses++;
                if (pulses == 1) first = i;
                if (pulses <= 15) trg[s] = pin(s, fid[pulses-1]);
                if (pulses == en_bit) en[s] = 1'b0;
                if (pulses == stop_bit) return;
                run = 1;
            end else if (!c && prev) begin
                if (run != h) bad++;
                run = 1;
            end else begin
                run++;
            end
            prev = c;
            if (vld[s] === 1'b1) begin
                done = 1'b1;
                len = i - first;
            end
        end
        trg[s] = pin(s, 1'b0);
        chk("clk_pulses", pulses, 15);
        chk("clk_halfper", bad, 0);
        chk("busy_frame", busy_lo, 0);
        chk("frame_len", len, 30 * h);
        chk("trig_valid", vld[s], 1);
        chk("trig_id", id[s], fid);
    endtask

    task automatic ack_frame(input int s);
        ack[s] = 1'b1;
        @(negedge clk);
        ack[s] = 1'b0;
        chk("ack_busy", pin(s, busy[s]), 0);
        chk("ack_valid", vld[s], 0);
    endtask

    initial begin
        int n, lo, hi;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            en[s] = 1'b1; div[s] = 8'd4; tmo[s] = 16'd0;
            trg[s] = pin(s, 1'b0); trst[s] = pin(s, 1'b0);
            ack[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy0", busy[0], 0);
        chk("rst_clk0", tclk[0], 0);
        chk("rst_valid0", vld[0], 0);
        chk("rst_id0", id[0], 0);
        chk("rst_cnt0", cnt[0], 0);
        chk("rst_to0", to[0], 0);
        chk("rst_busy1_pin", busy[1], 1);
        chk("rst_clk1_pin", tclk[1], 1);
        rst = 1'b0;

        run_frame(0, 15'h5A3C, 4, 16, 16);
        chk("cnt_after_a", cnt[0], 1);

        // backpressure with a second trigger while in DONE
        lo = 0; hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy[0] !== 1'b1) lo++;
            if (tclk[0] !== 1'b0) hi++;
            if (i == 50) trg[0] = 1'b1;
        end
        chk("bp_busy", lo, 0);
        chk("bp_clk", hi, 0);
        chk("bp_id", id[0], 15'h5A3C);
        chk("bp_cnt", cnt[0], 1);
        ack_frame(0);
        lo = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy[0] !== 1'b0) lo++;
        end
        chk("no_rearm_high", lo, 0);
        trg[0] = 1'b0;

        // timeout: counter reaches 0 after 20 cycles, pulse the cycle after
        tmo[0] = 16'd20;
        repeat (4) @(negedge clk);
        trg[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (busy[0] !== 1'b1 && n < 50);
        n = 0; hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (tclk[0] !== 1'b0) hi++;
        end while (to[0] !== 1'b1 && n < 100);
        chk("to_latency", n, 21);
        chk("to_busy", busy[0], 0);
        @(negedge clk);
        chk("to_pulse_len", to[0], 0);
        chk("to_clk", hi, 0);
        chk("to_valid", vld[0], 0);
        chk("to_cnt", cnt[0], 1);
        trg[0] = 1'b0;
        tmo[0] = 16'd0;

        // inverted pins, divider clamped to 2
        div[1] = 8'd0;
        run_frame(1, 15'h7FFF, 2, 16, 16);
        chk("inv_cnt", cnt[1], 1);
        ack_frame(1);
        chk("inv_idle_clk", tclk[1], 1);

        // SYS_RST during bit 7
        run_frame(0, 15'h0F0F, 4, 7, 16);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_clk", tclk[0], 0);
        chk("mid_rst_valid", vld[0], 0);
        chk("mid_rst_id", id[0], 0);
        chk("mid_rst_cnt", cnt[0], 0);
        chk("mid_rst_to", to[0], 0);
        @(negedge clk);
        rst = 1'b0;
        trg[0] = 1'b0;
        div[0] = 8'd3;
        run_frame(0, 15'h1234, 3, 16, 16);
        ack_frame(0);
        div[0] = 8'd2;
        run_frame(0, 15'h0001, 2, 16, 16);
        ack_frame(0);
        run_frame(0, 15'h4000, 2, 16, 16);
        ack_frame(0);
        chk("cnt_three", cnt[0], 3);
        trst[0] = 1'b1;
        repeat (3) @(negedge clk);
        trst[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("tlu_reset_cnt", cnt[0], 0);

        // enable low blocks a trigger
        en[0] = 1'b0;
        repeat (4) @(negedge clk);
        trg[0] = 1'b1;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy[0] !== 1'b0) hi++;
        end
        chk("en_block", hi, 0);
        trg[0] = 1'b0;
        en[0] = 1'b1;

        // enable dropped at bit 5 lets the frame finish
        div[0] = 8'd4;
        run_frame(0, 15'h2AAA, 4, 16, 5);
        chk("en_drop_cnt", cnt[0], 1);
        ack_frame(0);
        en[0] = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
